// File: rtl/pattern_scan_scheduler.sv
// Round-robin scheduler that feeds NREQ parallel frames, one at a time, MSB-first
// through a shared serial pattern matcher and reports match count / first position.
module pattern_scan_scheduler #(
  parameter int               NREQ        = 4,
  parameter int               FRAME_W     = 16,
  parameter int               PAT_W       = 5,
  parameter logic [PAT_W-1:0] RST_PATTERN = 5'b11011,
  parameter int               ID_W        = $clog2(NREQ),
  parameter int               CNT_W       = $clog2(FRAME_W + 1),
  parameter int               POS_W       = $clog2(FRAME_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic                      cfg_overlap,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*FRAME_W-1:0]   req_frame,
  output logic [NREQ-1:0]           req_ready,
  output logic                      busy,
  output logic                      match_pulse,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_W-1:0]          res_count,
  output logic [POS_W-1:0]          res_first_pos
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [PAT_W-1:0]   pattern_q;
  logic               overlap_q;
  logic [FRAME_W-1:0] frame_q;
  logic [ID_W-1:0]    id_q;
  logic [POS_W-1:0]   bit_idx_q;
  logic [PAT_W-1:0]   window_q;
  logic [FILL_W-1:0]  fill_q;
  logic [CNT_W-1:0]   count_q;
  logic [POS_W-1:0]   first_q;
  logic               match_pulse_q;
  logic               res_valid_q;
  logic [ID_W-1:0]    res_id_q;
  logic [CNT_W-1:0]   res_count_q;
  logic [POS_W-1:0]   res_first_pos_q;

  logic               grant_hit_s;
  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W-1:0]    rr_ptr_d;
  logic               scan_bit_s;
  logic [PAT_W-1:0]   window_d;
  logic               match_s;
  logic [FILL_W-1:0]  fill_d;
  logic [CNT_W-1:0]   count_d;
  logic [POS_W-1:0]   first_d;
  logic               last_bit_s;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return ID_W'(sum % NREQ);
  endfunction

  // Round-robin search: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_hit_s   = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_hit_s   = !grant_found_s && req_valid[wrap_idx(rr_ptr_q, i)];
      grant_idx_s   = grant_hit_s ? wrap_idx(rr_ptr_q, i) : grant_idx_s;
      grant_found_s = grant_found_s | grant_hit_s;
    end
    rr_ptr_d = (grant_idx_s == ID_W'(NREQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
  end

  // Matcher next-state: the frame register shifts left so its MSB is the current bit.
  always_comb begin
    scan_bit_s = frame_q[FRAME_W-1];
    window_d   = {window_q[PAT_W-2:0], scan_bit_s};
    match_s    = (state_q == ST_SCAN) && (fill_q >= FILL_W'(PAT_W - 1)) && (window_d == pattern_q);
    if (match_s && !overlap_q) begin
      fill_d = '0;
    end else if (fill_q == FILL_W'(PAT_W)) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FILL_W'(1);
    end
    count_d    = count_q + CNT_W'(match_s);
    first_d    = (match_s && (count_q == '0)) ? bit_idx_q : first_q;
    last_bit_s = (bit_idx_q == POS_W'(FRAME_W - 1));
  end

  // Control FSM, datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      pattern_q       <= RST_PATTERN;
      overlap_q       <= 1'b0;
      frame_q         <= '0;
      id_q            <= '0;
      bit_idx_q       <= '0;
      window_q        <= '0;
      fill_q          <= '0;
      count_q         <= '0;
      first_q         <= '0;
      match_pulse_q   <= 1'b0;
      res_valid_q     <= 1'b0;
      res_id_q        <= '0;
      res_count_q     <= '0;
      res_first_pos_q <= '0;
    end else begin
      match_pulse_q <= 1'b0;
      res_valid_q   <= 1'b0;
      // Config is only accepted in IDLE, so an accepted frame sees the new values.
      if (cfg_we && (state_q == ST_IDLE)) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_found_s) begin
            frame_q   <= req_frame[int'(grant_idx_s)*FRAME_W +: FRAME_W];
            id_q      <= grant_idx_s;
            rr_ptr_q  <= rr_ptr_d;
            bit_idx_q <= '0;
            window_q  <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            first_q   <= '0;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          frame_q       <= frame_q << 1;
          window_q      <= window_d;
          fill_q        <= fill_d;
          count_q       <= count_d;
          first_q       <= first_d;
          bit_idx_q     <= bit_idx_q + POS_W'(1);
          match_pulse_q <= match_s;
          if (last_bit_s) begin
            state_q         <= ST_DONE;
            res_valid_q     <= 1'b1;
            res_id_q        <= id_q;
            res_count_q     <= count_d;
            res_first_pos_q <= first_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = ((state_q == ST_IDLE) && !rst && grant_found_s)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
  assign busy          = (state_q != ST_IDLE);
  assign match_pulse   = match_pulse_q;
  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_count     = res_count_q;
  assign res_first_pos = res_first_pos_q;

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Self-checking bench for pattern_scan_scheduler: directed test-plan scenarios plus
// randomized frames/config checked against a sliding-window reference model.
module tb_pattern_scan_scheduler;

  localparam int NREQ    = 4;
  localparam int FRAME_W = 16;
  localparam int PAT_W   = 5;
  localparam logic [PAT_W-1:0]   DEF_PAT   = 5'b11011;
  localparam logic [FRAME_W-1:0] PLAN_FRM  = 16'b1101101101100000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_we;
  logic [PAT_W-1:0]        cfg_pattern;
  logic                    cfg_overlap;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*FRAME_W-1:0] req_frame;
  logic [NREQ-1:0]         req_ready;
  logic                    busy;
  logic                    match_pulse;
  logic                    res_valid;
  logic [1:0]              res_id;
  logic [4:0]              res_count;
  logic [3:0]              res_first_pos;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [PAT_W-1:0]   m_pat;
  bit                 m_ovl;
  int                 m_rr;
  logic [FRAME_W-1:0] frames [NREQ];

  pattern_scan_scheduler dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .req_valid(req_valid), .req_frame(req_frame),
    .req_ready(req_ready), .busy(busy), .match_pulse(match_pulse),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .res_first_pos(res_first_pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: slide a PAT_W window along the frame; in non-overlap mode a match
  // may not reuse any bit of the previous match.
  function automatic void model_scan(input logic [FRAME_W-1:0] f, input logic [PAT_W-1:0] p,
                                     input bit ovl, output int cnt, output int first,
                                     output logic [FRAME_W+1:0] pulses);
    int last;
    logic [FRAME_W-1:0] sh;
    last = -100; cnt = 0; first = 0; pulses = '0;
    for (int k = PAT_W - 1; k < FRAME_W; k++) begin
      sh = f >> (FRAME_W - 1 - k);
      if (sh[PAT_W-1:0] == p && (ovl || (k - last) >= PAT_W)) begin
        if (cnt == 0) first = k;
        cnt++;
        last = k;
        pulses[k+2] = 1'b1;
      end
    end
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int rr);
    for (int i = 0; i < NREQ; i++) if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  task automatic load_frames();
    for (int i = 0; i < NREQ; i++) req_frame[i*FRAME_W +: FRAME_W] = frames[i];
  endtask

  task automatic apply_cfg(input logic [PAT_W-1:0] p, input bit o);
    cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = o;
    @(negedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Raise the request mask, wait (bounded) for the accept, then observe the
  // following FRAME_W+1 cycles; offsets are relative to the accept cycle.
  task automatic do_frame(input logic [NREQ-1:0] vmask, input bit hold, output int g,
                          output int tacc, output logic [FRAME_W+1:0] pulses, output int roff,
                          output int rid, output int rcnt, output int rfirst,
                          output logic [NREQ-1:0] rdy);
    int waited;
    waited = 0; g = -1; tacc = -1; pulses = '0; roff = -1; rid = -1; rcnt = -1; rfirst = -1;
    load_frames();
    req_valid = vmask; #1;
    while (req_ready == '0 && waited < 40) begin @(negedge clk); #1; waited++; end
    rdy = req_ready;
    if (req_ready == '0) return;
    tacc = cyc;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
    @(negedge clk); #1;
    cfg_we = 1'b0;
    if (!hold) req_valid[g] = 1'b0;
    for (int off = 1; off <= FRAME_W + 1; off++) begin
      if (match_pulse) pulses[off] = 1'b1;
      if (res_valid && roff < 0) begin
        roff = off; rid = res_id; rcnt = res_count; rfirst = res_first_pos;
      end
      if (off <= FRAME_W) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    for (int i = 0; i < NREQ; i++) frames[i] = PLAN_FRM;
    load_frames();
    req_valid = 4'b1111;
    repeat (3) @(negedge clk); #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({busy, match_pulse, res_valid, res_id, res_count, res_first_pos} !== 14'd0)
      $display("FAIL reset_outputs: got busy=%b mp=%b rv=%b id=%0d cnt=%0d pos=%0d want all 0",
               busy, match_pulse, res_valid, res_id, res_count, res_first_pos);
    else pass_cnt++;
    rst = 1'b0; req_valid = '0;
    m_pat = DEF_PAT; m_ovl = 1'b0; m_rr = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_defaults();
    int g, tacc, roff, rid, rcnt, rfirst;
    logic [FRAME_W+1:0] pl;
    logic [NREQ-1:0] rdy;
    frames[0] = PLAN_FRM;
    do_frame(4'b0001, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
    m_rr = 1;
    total_cnt++;
    if (rdy !== 4'b0001) $display("FAIL defaults_ready: got %b want 0001", rdy); else pass_cnt++;
    total_cnt++;
    if (pl !== 18'h01040) $display("FAIL defaults_pulses: got %h want 01040", pl); else pass_cnt++;
    total_cnt++;
    if (roff !== FRAME_W + 1) $display("FAIL defaults_res_time: got %0d want 17", roff); else pass_cnt++;
    total_cnt++;
    if (rid !== 0 || rcnt !== 2 || rfirst !== 4)
      $display("FAIL defaults_result: got id=%0d cnt=%0d pos=%0d want 0/2/4", rid, rcnt, rfirst);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    int g, tacc, roff, rid, rcnt, rfirst;
    logic [FRAME_W+1:0] pl;
    logic [NREQ-1:0] rdy;
    @(negedge clk); #1;
    apply_cfg(DEF_PAT, 1'b1);
    m_ovl = 1'b1;
    do_frame(4'b0001, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
    m_rr = 1;
    total_cnt++;
    if (pl !== 18'h01240) $display("FAIL overlap_pulses: got %h want 01240", pl); else pass_cnt++;
    total_cnt++;
    if (rcnt !== 3 || rfirst !== 4)
      $display("FAIL overlap_result: got cnt=%0d pos=%0d want 3/4", rcnt, rfirst);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int g, tacc, roff, rid, rcnt, rfirst, prev_t, ecnt, efirst;
    int exp_seq [4] = '{1, 3, 1, 3};
    logic [FRAME_W+1:0] pl, epl;
    logic [NREQ-1:0] rdy;
    frames[1] = 16'($urandom); frames[3] = 16'($urandom);
    prev_t = -1;
    for (int n = 0; n < 4; n++) begin
      do_frame(4'b1010, 1'b1, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
      total_cnt++;
      if (g !== exp_seq[n]) $display("FAIL rr_grant%0d: got %0d want %0d", n, g, exp_seq[n]);
      else pass_cnt++;
      if (n > 0) begin
        total_cnt++;
        if (tacc - prev_t !== FRAME_W + 2)
          $display("FAIL rr_spacing%0d: got %0d want %0d", n, tacc - prev_t, FRAME_W + 2);
        else pass_cnt++;
      end
      prev_t = tacc;
      model_scan(frames[exp_seq[n]], m_pat, m_ovl, ecnt, efirst, epl);
      total_cnt++;
      if (rid !== exp_seq[n] || rcnt !== ecnt || rfirst !== efirst || pl !== epl)
        $display("FAIL rr_result%0d: got id=%0d cnt=%0d pos=%0d pl=%h want %0d/%0d/%0d/%h",
                 n, rid, rcnt, rfirst, pl, exp_seq[n], ecnt, efirst, epl);
      else pass_cnt++;
    end
    req_valid = '0;
    m_rr = 0;
  endtask

  task automatic test_cfg_during_scan();
    int g, tacc, roff, rid, rcnt, rfirst;
    logic [FRAME_W+1:0] pl;
    logic [NREQ-1:0] rdy;
    @(negedge clk); #1;
    apply_cfg(DEF_PAT, 1'b0);
    m_ovl = 1'b0;
    frames[0] = PLAN_FRM;
    fork
      do_frame(4'b0001, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
      begin repeat (6) @(negedge clk); #1; apply_cfg(5'b00000, 1'b1); end
    join
    total_cnt++;
    if (rcnt !== 2 || rfirst !== 4 || pl !== 18'h01040)
      $display("FAIL busycfg_current: got cnt=%0d pos=%0d pl=%h want 2/4/01040", rcnt, rfirst, pl);
    else pass_cnt++;
    frames[0] = 16'h0000;
    do_frame(4'b0001, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
    total_cnt++;
    if (rcnt !== 0 || rfirst !== 0 || pl !== '0)
      $display("FAIL busycfg_next: got cnt=%0d pos=%0d pl=%h want 0/0/0", rcnt, rfirst, pl);
    else pass_cnt++;
    m_rr = 1;
  endtask

  task automatic test_reset_midscan();
    int g, tacc, roff, rid, rcnt, rfirst, t0, waited, bad;
    logic [FRAME_W+1:0] pl;
    logic [NREQ-1:0] rdy;
    @(negedge clk); #1;
    apply_cfg(5'b00111, 1'b1);
    frames[2] = 16'b0011100111001110;
    load_frames();
    req_valid = 4'b0100; #1;
    waited = 0;
    while (req_ready == '0 && waited < 40) begin @(negedge clk); #1; waited++; end
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL midrst_grant: got %b want 0100", req_ready);
    else pass_cnt++;
    t0 = cyc;
    @(negedge clk); #1;
    req_valid = '0;
    repeat (7) @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid !== 1'b0 || match_pulse !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk); #1;
    end
    total_cnt++;
    if (bad !== 0 || cyc - t0 !== 29)
      $display("FAIL midrst_quiet: got %0d active cycles want 0 (span %0d)", bad, cyc - t0);
    else pass_cnt++;
    m_pat = DEF_PAT; m_ovl = 1'b0; m_rr = 0;
    frames[1] = PLAN_FRM; frames[3] = PLAN_FRM;
    do_frame(4'b1010, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
    m_rr = 2;
    total_cnt++;
    if (g !== 1) $display("FAIL midrst_rrptr: got %0d want 1", g); else pass_cnt++;
    total_cnt++;
    if (rcnt !== 2 || rfirst !== 4 || pl !== 18'h01040)
      $display("FAIL midrst_pattern: got cnt=%0d pos=%0d pl=%h want 2/4/01040", rcnt, rfirst, pl);
    else pass_cnt++;
  endtask

  task automatic test_cfg_same_cycle();
    int g, tacc, roff, rid, rcnt, rfirst;
    logic [FRAME_W+1:0] pl;
    logic [NREQ-1:0] rdy;
    @(negedge clk); #1;
    frames[2] = 16'b1010101010101010;
    cfg_we = 1'b1; cfg_pattern = 5'b10101; cfg_overlap = 1'b0;
    do_frame(4'b0100, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
    m_pat = 5'b10101; m_ovl = 1'b0; m_rr = 3;
    total_cnt++;
    if (g !== 2 || rid !== 2) $display("FAIL samecyc_id: got g=%0d id=%0d want 2", g, rid);
    else pass_cnt++;
    total_cnt++;
    if (rcnt !== 2 || rfirst !== 4 || pl !== 18'h01040)
      $display("FAIL samecyc_result: got cnt=%0d pos=%0d pl=%h want 2/4/01040", rcnt, rfirst, pl);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int g, tacc, roff, rid, rcnt, rfirst, eg, ecnt, efirst, op;
    logic [FRAME_W+1:0] pl, epl;
    logic [NREQ-1:0] rdy, mask;
    logic [4*PAT_W-1:0] rep;
    logic [PAT_W-1:0] np;
    bit no;
    for (int i = 0; i < NREQ; i++) frames[i] = 16'($urandom);
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      np = 5'($urandom_range(0, 31)); no = 1'($urandom_range(0, 1));
      if (op == 1) begin
        apply_cfg(np, no);
      end else if (op == 2) begin
        @(negedge clk); #1;
        cfg_we = 1'b1; cfg_pattern = np; cfg_overlap = no;
        m_pat = np; m_ovl = no;
      end
      mask = 4'($urandom_range(1, 15));
      eg = exp_grant(mask, m_rr);
      if ($urandom_range(0, 1) == 1) begin
        rep = {4{m_pat}};
        frames[eg] = rep[4*PAT_W-1 -: FRAME_W] ^ 16'(1 << $urandom_range(0, 20));
      end
      do_frame(mask, 1'b0, g, tacc, pl, roff, rid, rcnt, rfirst, rdy);
      model_scan(frames[eg], m_pat, m_ovl, ecnt, efirst, epl);
      total_cnt++;
      if (g !== eg || rdy !== 4'(1 << eg))
        $display("FAIL rand%0d_grant: got %0d (%b) want %0d", it, g, rdy, eg);
      else pass_cnt++;
      total_cnt++;
      if (pl !== epl) $display("FAIL rand%0d_pulses: got %h want %h", it, pl, epl); else pass_cnt++;
      total_cnt++;
      if (roff !== FRAME_W + 1 || rid !== eg)
        $display("FAIL rand%0d_strobe: got off=%0d id=%0d want %0d/%0d", it, roff, rid, FRAME_W + 1, eg);
      else pass_cnt++;
      total_cnt++;
      if (rcnt !== ecnt || rfirst !== efirst)
        $display("FAIL rand%0d_result: got cnt=%0d pos=%0d want %0d/%0d", it, rcnt, rfirst, ecnt, efirst);
      else pass_cnt++;
      m_rr = (eg + 1) % NREQ;
      frames[eg] = 16'($urandom);
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    req_valid = '0; req_frame = '0;
    test_reset();
    test_defaults();
    test_overlap();
    test_round_robin();
    test_cfg_during_scan();
    test_reset_midscan();
    test_cfg_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
